gcm_text_combiner: RTL
======================

Name: gcm_text_combiner

Overview:
- Receiving end of the plaintext delay path in the AES-GCM datapath.
- Buffers plaintext blocks accepted upstream in a FIFO, in step with the AES-CTR keystream pipeline.
- When a keystream block emerges from the AES pipeline, pops the oldest plaintext block and produces ciphertext = text XOR keystream, one registered stage later.
- Replaces the fixed-length register chain with an elastic, occupancy-checked buffer feeding the GHASH stage.

Parameters:
- WIDTH, 128, block width in bits; ports use [0:WIDTH-1] ordering, bit 0 = MSB of block.
- DEPTH, 32, FIFO entries; must be ≥ AES pipeline latency + 1; power of two.
- CW, $clog2(DEPTH+1), width of occupancy count.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- i_text_valid  in  1  plaintext block offered.
- i_text  in  WIDTH  plaintext block.
- i_text_last  in  1  final block of message, stored with the block.
- o_text_ready  out  1  FIFO can accept a block this cycle.
- i_ks_valid  in  1  keystream block present; no backpressure possible.
- i_keystream  in  WIDTH  AES-CTR keystream block.
- o_out_valid  out  1  o_out_text valid this cycle (single-cycle pulse per block).
- o_out_text  out  WIDTH  ciphertext block.
- o_out_last  out  1  last flag of the popped block.
- o_count  out  CW  current FIFO occupancy.
- o_underflow  out  1  sticky: keystream arrived with FIFO empty.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on rst; it takes effect at the clk edge where rst=1 and overrides all other inputs that cycle.
- Reset values: o_out_valid=0, o_out_text=0, o_out_last=0, o_count=0, o_underflow=0, o_text_ready=1. Write/read pointers = 0. FIFO contents are not cleared.
- Storage: FIFO entry = {last, text}, WIDTH+1 bits. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Ready: o_text_ready = (o_count != DEPTH). It is a registered-state function only, with no combinational path from i_ks_valid. A pop in the same cycle does not make a full FIFO ready.
- Write: on i_text_valid && o_text_ready, store the entry at wr_ptr and increment wr_ptr. If not ready, the input is ignored; upstream holds it.
- Read with data: on i_ks_valid && (o_count != 0):
  - next cycle o_out_valid=1, o_out_text = mem[rd_ptr] XOR i_keystream, o_out_last = stored last;
  - increment rd_ptr.
  - Latency from i_ks_valid to o_out_valid: exactly 1 cycle.
- Read on empty: on i_ks_valid && (o_count == 0):
  - no pop; next cycle o_out_valid=0;
  - o_underflow set, held until rst.
  - No write-to-read bypass: a block written in the same cycle is not visible to that cycle's read.
- Idle: when i_ks_valid=0, next o_out_valid=0. o_out_text and o_out_last hold their last values.
- Simultaneous write and pop, FIFO non-empty and not full: o_count unchanged, both pointers advance.
- Count update: o_count = count + write_accepted - pop_done, registered. Never exceeds DEPTH and never goes negative.
- Reset mid-message: buffered blocks are discarded. An i_ks_valid in the reset cycle is ignored and does not set o_underflow.

Test Plan:
- Reset, then write 3 blocks 0x00..01, 0x00..02, 0x00..03 (last on 3rd), then i_ks_valid with keystream 0xFF..FF for 3 cycles:
  - o_out_text = 0xFF..FE, 0xFF..FD, 0xFF..FC, each 1 cycle after its ks;
  - o_out_last=1 only on 3rd;
  - o_count returns to 0.
- Steady stream, DEPTH=32: write every cycle; ks_valid starts 16 cycles later, every cycle, data = counter pattern:
  - o_count plateaus at 16;
  - every output equals text[i] XOR ks[i];
  - no underflow.
- Fill to 32 with no ks:
  - o_text_ready=0 at count 32; 33rd offered block ignored.
  - Assert ks_valid and text_valid together: pop occurs, write rejected, count=31. Next cycle ready=1.
- Empty FIFO, i_ks_valid=1 one cycle:
  - o_out_valid stays 0, o_underflow=1 and stays 1.
  - A later normal write/pop still produces correct output with o_underflow still 1.
- Wrap-around: push/pop 100 blocks with random gaps, occupancy ≤ 20:
  - output order and XOR correct across pointer wrap at 31→0.
- Reset with count=5 mid-stream:
  - next cycle o_count=0, o_out_valid=0, o_underflow=0.
  - A new block written then popped yields fresh data, not stale entries.

Source files
------------

// File: rtl/gcm_text_combiner.sv
// ---------------------------------------------------------------------------
// gcm_text_combiner
//
// Receiving end of the AES-GCM plaintext delay path.  Plaintext blocks are
// parked in an elastic FIFO while their keystream travels through the AES-CTR
// pipeline.  Each keystream block pops the oldest plaintext block.  The
// ciphertext (text XOR keystream) is registered one cycle later and goes to
// the GHASH stage.
//
// Ports
//   clk           clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   i_text_valid  plaintext block offered
//   i_text        plaintext block ([0] is the block MSB)
//   i_text_last   final block of the message, stored with the block
//   o_text_ready  FIFO can accept a block this cycle (not full)
//   i_ks_valid    keystream block present (no backpressure)
//   i_keystream   AES-CTR keystream block
//   o_out_valid   single-cycle pulse per ciphertext block
//   o_out_text    ciphertext block
//   o_out_last    last flag of the popped block
//   o_count       current FIFO occupancy
//   o_underflow   sticky: keystream arrived while the FIFO was empty
// ---------------------------------------------------------------------------
module gcm_text_combiner #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 32,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_text_valid,
    input  logic [0:WIDTH-1] i_text,
    input  logic             i_text_last,
    output logic             o_text_ready,
    input  logic             i_ks_valid,
    input  logic [0:WIDTH-1] i_keystream,
    output logic             o_out_valid,
    output logic [0:WIDTH-1] o_out_text,
    output logic             o_out_last,
    output logic [CW-1:0]    o_count,
    output logic             o_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0] EMPTY_C = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE_C = {{(AW-1){1'b0}}, 1'b1};

    // Entry layout: bit 0 holds the last flag, bits 1..WIDTH hold the text.
    logic [0:WIDTH]   mem_r [0:DEPTH-1];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic             wr_en_s;
    logic             rd_en_s;
    logic             out_valid_r;
    logic [0:WIDTH-1] out_text_r;
    logic             out_last_r;
    logic             underflow_r;

    // Ready depends only on registered occupancy, so a same-cycle pop never
    // makes a full FIFO accept a block.
    assign wr_en_s = i_text_valid && (count_r != FULL_C);
    // Reads see only the registered occupancy: no write-to-read bypass.
    assign rd_en_s = i_ks_valid && (count_r != EMPTY_C);

    // Next occupancy from the accepted write and the performed pop.
    always_comb begin
        count_next_s = count_r;
        case ({wr_en_s, rd_en_s})
            2'b10:   count_next_s = count_r + ONE_C;
            2'b01:   count_next_s = count_r - ONE_C;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage write; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_en_s) begin
            mem_r[wr_ptr_r] <= {i_text_last, i_text};
        end
    end

    // Pointers, occupancy, ciphertext output stage and sticky underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= EMPTY_C;
            out_valid_r <= 1'b0;
            out_text_r  <= {WIDTH{1'b0}};
            out_last_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            count_r     <= count_next_s;
            out_valid_r <= rd_en_s;
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (rd_en_s) begin
                rd_ptr_r   <= rd_ptr_r + PTR_ONE_C;
                out_text_r <= mem_r[rd_ptr_r][1:WIDTH] ^ i_keystream;
                out_last_r <= mem_r[rd_ptr_r][0];
            end
            if (i_ks_valid && (count_r == EMPTY_C)) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign o_text_ready = (count_r != FULL_C);
    assign o_out_valid  = out_valid_r;
    assign o_out_text   = out_text_r;
    assign o_out_last   = out_last_r;
    assign o_count      = count_r;
    assign o_underflow  = underflow_r;

endmodule
